mac_operand_scheduler: RTL
==========================

Name: mac_operand_scheduler

Overview:
- Transmitter side of the PE multiply-accumulate protocol.
- Buffers one 3x3 kernel (9 signed weights) and consumes a stream of feature taps.
- For each tap it drives weight-latch, data-valid and shift_data into one MAC unit, then feeds each returned partial sum back as the next tap's shift_data.
- After 9 taps it emits the finished ADD9 sum downstream with valid/ready.

Parameters:
- QUAN_BITS, 8, signed weight/feature width.
- ADD9_ALL_BITS, 20, accumulator width (2*QUAN_BITS+4).
- KERNEL_TAPS, 9, taps per output point.

Ports:
- s_clk  in  1  clock.
- s_rst_n  in  1  reset; one clock, asynchronous, active-low.
- i_weight_valid  in  1  weight stream valid.
- o_weight_ready  out  1  weight stream ready.
- i_weight  in  QUAN_BITS  signed weight, tap order 0..8.
- i_kernel_clr  in  1  pulse; invalidates the weight bank.
- i_feat_valid  in  1  feature stream valid.
- o_feat_ready  out  1  feature stream ready.
- i_feat  in  QUAN_BITS  signed feature tap.
- o_pe_clr  out  1  active-high clear to the MAC, one cycle per point.
- o_k_weight_valid  out  1  MAC weight latch strobe.
- o_kernel_weight  out  QUAN_BITS  weight to MAC.
- o_f_data_valid  out  1  MAC data strobe.
- o_feature_data  out  QUAN_BITS  feature to MAC.
- o_shift_data  out  ADD9_ALL_BITS  partial sum to MAC.
- i_mac_rlst_valid  in  1  MAC result strobe.
- i_mac_rlst  in  ADD9_ALL_BITS  MAC result.
- o_sum_valid  out  1  output valid.
- i_sum_ready  in  1  output ready.
- o_sum  out  ADD9_ALL_BITS  finished 9-tap sum.
- o_err  out  1  sticky; set on an unexpected MAC result.

Behaviour:
- Reset:
  - All outputs 0.
  - Weight bank invalid; state ST_LOAD; tap counter 0.
- ST_LOAD:
  - o_weight_ready=1; each weight handshake writes bank[cnt] and increments cnt.
  - On the 9th handshake: cnt=0, bank valid, go to ST_CLR.
- ST_CLR:
  - o_pe_clr=1 for exactly one cycle; accumulator=0; go to ST_W.
- ST_W:
  - o_k_weight_valid=1; o_kernel_weight=bank[cnt]; o_feat_ready=1.
  - If i_feat_valid: register i_feat into o_feature_data and go to ST_D.
  - Otherwise stay; the weight is re-strobed each cycle, which is harmless.
- ST_D:
  - o_f_data_valid=1 for one cycle; o_shift_data=accumulator.
  - o_feature_data and o_shift_data are held stable until the result returns.
  - Go to ST_WAIT.
- ST_WAIT:
  - The MAC result arrives 2 cycles after o_f_data_valid.
  - On i_mac_rlst_valid: accumulator=i_mac_rlst.
  - If cnt==8: go to ST_OUT; else cnt++ and go to ST_W.
- Tap period: 4 cycles with no stall. Point latency: 1 + 9*4 = 37 cycles from ST_CLR to o_sum_valid.
- ST_OUT:
  - o_sum_valid=1, o_sum=accumulator; both held until i_sum_ready.
  - On handshake: cnt=0; go to ST_LOAD if a kernel clear is pending or the bank is invalid, else ST_CLR.
- i_kernel_clr:
  - In ST_LOAD: restart loading at cnt=0.
  - In any other state: latched as pending and applied after the current point's output handshake. It never aborts a point.
- Arithmetic:
  - All signed. The accumulator takes the MAC result verbatim; no saturation in this block.
- o_err:
  - Set when i_mac_rlst_valid is seen outside ST_WAIT; that result is ignored.
  - Cleared only by reset.
- Simultaneous i_sum_ready and i_kernel_clr in ST_OUT: go to ST_LOAD.
- Asynchronous reset mid-point: the point is discarded; the bank must be reloaded.

Optional Feature:
- ZERO_SKIP_EN defined:
  - In ST_W, a feature handshake where bank[cnt]==0 or i_feat==0 skips ST_D and ST_WAIT.
  - The accumulator is unchanged, cnt advances, and no MAC strobes are issued.
  - If that tap was the last one, go to ST_OUT directly.
- Undefined: every tap goes through the MAC.

Decomposition:
- Shared hyper-parameter include holds:
  - QUAN_BITS, ADD9_ALL_BITS, KERNEL_TAPS.
  - State encodings ST_LOAD/ST_CLR/ST_W/ST_D/ST_WAIT/ST_OUT.
- One natural sub-module, mac_weight_bank: 9-entry register file with write pointer, valid flag and read mux.

Test Plan:
- Load weights 1..9 and stream features all 1 -> o_sum=45, o_sum_valid exactly 37 cycles after o_pe_clr; o_pe_clr pulsed once.
- Weights all -128, features all 127 -> o_sum=-146304 (signed, fits 20 bits).
- Hold i_sum_ready=0 for 10 cycles -> o_sum stable, o_feat_ready=0 throughout; next point starts only after the handshake.
- Pulse i_kernel_clr at tap 4, then load new weights all 2 with features all 3 -> current point completes with the old weights, next o_sum=54.
- Inject i_mac_rlst_valid during ST_W -> o_err=1 sticky; accumulator unchanged.
- With ZERO_SKIP_EN: weights {0,1,0,1,0,1,0,1,0}, features all 5 -> o_sum=20; only 4 o_f_data_valid pulses.

Source files
------------

// File: rtl/mac_operand_scheduler_pkg.sv
// Shared hyper-parameters and FSM encodings for the MAC operand scheduler.
package mac_operand_scheduler_pkg;
  localparam int QUAN_BITS     = 8;
  localparam int ADD9_ALL_BITS = 2 * QUAN_BITS + 4;
  localparam int KERNEL_TAPS   = 9;
  localparam int TAP_CNT_W     = $clog2(KERNEL_TAPS);

  localparam logic [2:0] ST_LOAD = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_W    = 3'd2;
  localparam logic [2:0] ST_D    = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_OUT  = 3'd5;

  function automatic logic is_last_tap(input logic [TAP_CNT_W-1:0] idx);
    return idx == TAP_CNT_W'(KERNEL_TAPS - 1);
  endfunction
endpackage

// File: rtl/mac_weight_bank.sv
// 9-entry kernel weight store: sequential write pointer, valid once full, random read.
// Zero latency on read; writes accepted whenever asserted, clear wins over write.
module mac_weight_bank
  import mac_operand_scheduler_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [QUAN_BITS-1:0] i_wr_data,
  input  logic [TAP_CNT_W-1:0] i_rd_idx,
  output logic [QUAN_BITS-1:0] o_rd_data,
  output logic                 o_wr_last,
  output logic                 o_valid
);
  logic [QUAN_BITS-1:0] r_bank [KERNEL_TAPS];
  logic [TAP_CNT_W-1:0] r_wr_ptr;
  logic                 r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < KERNEL_TAPS; i++) r_bank[i] <= '0;
      r_wr_ptr <= '0;
      r_valid  <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_valid  <= 1'b0;
    end else if (i_wr_en) begin
      r_bank[r_wr_ptr] <= i_wr_data;
      if (is_last_tap(r_wr_ptr)) begin
        r_wr_ptr <= '0;
        r_valid  <= 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  assign o_rd_data = (i_rd_idx < TAP_CNT_W'(KERNEL_TAPS)) ? r_bank[i_rd_idx] : '0;
  assign o_wr_last = is_last_tap(r_wr_ptr);
  assign o_valid   = r_valid;
endmodule

// File: rtl/mac_operand_scheduler.sv
// Feeds one MAC unit tap by tap from a buffered 3x3 kernel; 37-cycle point latency, 4-cycle taps.
// Output held until i_sum_ready; feature input stalls meanwhile. ZERO_SKIP_EN bypasses zero products.
module mac_operand_scheduler
  import mac_operand_scheduler_pkg::*;
(
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic                     i_weight_valid,
  output logic                     o_weight_ready,
  input  logic [QUAN_BITS-1:0]     i_weight,
  input  logic                     i_kernel_clr,
  input  logic                     i_feat_valid,
  output logic                     o_feat_ready,
  input  logic [QUAN_BITS-1:0]     i_feat,
  output logic                     o_pe_clr,
  output logic                     o_k_weight_valid,
  output logic [QUAN_BITS-1:0]     o_kernel_weight,
  output logic                     o_f_data_valid,
  output logic [QUAN_BITS-1:0]     o_feature_data,
  output logic [ADD9_ALL_BITS-1:0] o_shift_data,
  input  logic                     i_mac_rlst_valid,
  input  logic [ADD9_ALL_BITS-1:0] i_mac_rlst,
  output logic                     o_sum_valid,
  input  logic                     i_sum_ready,
  output logic [ADD9_ALL_BITS-1:0] o_sum,
  output logic                     o_err
);
  logic [2:0]               r_state, w_state_nxt;
  logic [TAP_CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ADD9_ALL_BITS-1:0] r_acc, w_acc_nxt;
  logic [QUAN_BITS-1:0]     r_feat;
  logic                     r_clr_pend, r_err;
  logic                     r_weight_ready, r_pe_clr, r_k_wv, r_feat_ready, r_f_dv, r_sum_valid;
  logic [QUAN_BITS-1:0]     w_rd_weight;
  logic                     w_bank_valid, w_bank_wr_last, w_bank_clr, w_bank_wr;
  logic                     w_feat_hs, w_sum_hs, w_last, w_skip;

  assign w_feat_hs  = i_feat_valid && r_feat_ready;
  assign w_sum_hs   = r_sum_valid && i_sum_ready;
  assign w_last     = is_last_tap(r_cnt);
  assign w_bank_wr  = i_weight_valid && r_weight_ready && !i_kernel_clr;
  // A deferred clear lands on the output handshake so the running point keeps its kernel.
  assign w_bank_clr = ((r_state == ST_LOAD) && i_kernel_clr) ||
                      (w_sum_hs && (r_clr_pend || i_kernel_clr));

`ifdef ZERO_SKIP_EN
  assign w_skip = (w_rd_weight == '0) || (i_feat == '0);
`else
  assign w_skip = 1'b0;
`endif

  mac_weight_bank u_bank (
    .i_clk     (s_clk),
    .i_rst_n   (s_rst_n),
    .i_clr     (w_bank_clr),
    .i_wr_en   (w_bank_wr),
    .i_wr_data (i_weight),
    .i_rd_idx  (r_cnt),
    .o_rd_data (w_rd_weight),
    .o_wr_last (w_bank_wr_last),
    .o_valid   (w_bank_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    case (r_state)
      ST_LOAD: if (w_bank_wr && w_bank_wr_last) w_state_nxt = ST_CLR;
      ST_CLR: begin
        w_acc_nxt   = '0;
        w_state_nxt = ST_W;
      end
      ST_W: begin
        if (w_feat_hs) begin
          if (!w_skip)     w_state_nxt = ST_D;
          else if (w_last) w_state_nxt = ST_OUT;
          else             w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_D: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_mac_rlst_valid) begin
          w_acc_nxt = i_mac_rlst;
          if (w_last) begin
            w_state_nxt = ST_OUT;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = ST_W;
          end
        end
      end
      ST_OUT: begin
        if (w_sum_hs) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_clr_pend || i_kernel_clr || !w_bank_valid) ? ST_LOAD : ST_CLR;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state        <= ST_LOAD;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_feat         <= '0;
      r_clr_pend     <= 1'b0;
      r_err          <= 1'b0;
      r_weight_ready <= 1'b0;
      r_pe_clr       <= 1'b0;
      r_k_wv         <= 1'b0;
      r_feat_ready   <= 1'b0;
      r_f_dv         <= 1'b0;
      r_sum_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      if (w_feat_hs) r_feat <= i_feat;
      if (w_sum_hs)                                  r_clr_pend <= 1'b0;
      else if (i_kernel_clr && r_state != ST_LOAD)   r_clr_pend <= 1'b1;
      if (i_mac_rlst_valid && r_state != ST_WAIT) r_err <= 1'b1;
      // Strobes are registered from the next state so they are all low while in reset.
      r_weight_ready <= (w_state_nxt == ST_LOAD);
      r_pe_clr       <= (w_state_nxt == ST_CLR);
      r_k_wv         <= (w_state_nxt == ST_W);
      r_feat_ready   <= (w_state_nxt == ST_W);
      r_f_dv         <= (w_state_nxt == ST_D);
      r_sum_valid    <= (w_state_nxt == ST_OUT);
    end
  end

  assign o_weight_ready   = r_weight_ready;
  assign o_feat_ready     = r_feat_ready;
  assign o_pe_clr         = r_pe_clr;
  assign o_k_weight_valid = r_k_wv;
  assign o_kernel_weight  = w_rd_weight;
  assign o_f_data_valid   = r_f_dv;
  assign o_feature_data   = r_feat;
  assign o_shift_data     = r_acc;
  assign o_sum_valid      = r_sum_valid;
  assign o_sum            = r_acc;
  assign o_err            = r_err;
endmodule
